mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, RAM address width.
REQ-002 Parameter: DATA_W, 32, RAM data width.
REQ-003 iCLK  input  1  single clock; all state updates on rising edge.
REQ-004 iRST  input  1  reset; synchronous and active-high.
REQ-005 iREQ_F  input  1  fetch read request, held high until oDONE_F.
REQ-006 iADDR_F  input  ADDR_W  fetch address.
REQ-007 iREQ_I  input  1  load (I-type) read request, held high until oDONE_I.
REQ-008 iADDR_I  input  ADDR_W  load address.
REQ-009 iREQ_S  input  1  store (S-type) write request, held high until oDONE_S.
REQ-010 iADDR_S  input  ADDR_W  store address.
REQ-011 iDATA_S  input  DATA_W  store write data.
REQ-012 oDONE_F, oDONE_I, oDONE_S  output  1 each  one-cycle completion pulse per requester.
REQ-013 oRDATA  output  DATA_W  read data; valid in the oDONE_F / oDONE_I cycle.
REQ-014 oBUSY  output  1  high whenever the FSM is not in IDLE.
REQ-015 oRAM_CE, oRAM_RD, oRAM_WR  output  1 each  RAM strobes.
REQ-016 oRAM_ADDR  output  ADDR_W  RAM address.
REQ-017 oRAM_DATA_WR  output  DATA_W  RAM write data.
REQ-018 iRAM_DATA_RD  input  DATA_W  RAM read data; valid the cycle after a CE+RD strobe.

Function
REQ-019 FSM states:
- IDLE -> ACCESS when any request is high at the clock edge; winner is latched.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-020 Arbitration is round-robin over order F, I, S using a 2-bit pointer.
- Search for the winner starts at the pointer.
- After a grant, the pointer moves to the requester after the winner (S wraps to F).
REQ-021 Winner address, data and direction (S = write; F and I = read) are registered on the IDLE->ACCESS edge and held until RESP ends.
REQ-022 ACCESS cycle drives the RAM:
- oRAM_CE = 1.
- Read: oRAM_RD = 1, oRAM_WR = 0.
- Write: oRAM_WR = 1, oRAM_RD = 0.
- oRAM_ADDR and oRAM_DATA_WR take the latched values.
REQ-023 All RAM strobes are 0 outside ACCESS; oRAM_ADDR and oRAM_DATA_WR hold their last values.
REQ-024 RESP cycle:
- Pulses exactly one oDONE_x, for the latched winner.
- For reads, oRDATA = iRAM_DATA_RD combinationally in that cycle.
REQ-025 oRDATA is registered and holds the last read value outside RESP.
REQ-026 Latency: request sampled in IDLE at edge t -> ACCESS in cycle t+1 -> oDONE in cycle t+2.
REQ-027 Back-to-back throughput: one transaction per 3 cycles; a request still high in the cycle after its oDONE is treated as a new request.
REQ-028 Request deasserted during ACCESS/RESP: the transaction completes and its oDONE still pulses.
REQ-029 Requests arriving during ACCESS/RESP wait and are arbitrated only in IDLE.
REQ-030 oBUSY = 1 in ACCESS and RESP, 0 in IDLE.
REQ-031 A write-read to the same address in consecutive transactions returns the written data; the RAM is treated as write-first across transactions.

Reset
REQ-032 iRST high at a clock edge, in any state including mid-ACCESS or mid-RESP:
- FSM returns to IDLE.
- Pointer returns to F.
- All oDONE_x, oRAM_CE, oRAM_RD, oRAM_WR and oBUSY are 0.
- oRAM_ADDR, oRAM_DATA_WR and oRDATA are cleared to 0.
REQ-033 A transaction interrupted by reset produces no oDONE; requesters must re-request.
REQ-034 While iRST is high, requests are ignored and no RAM strobe is issued.

Verification
REQ-035 Single fetch: after reset, iREQ_F=1, iADDR_F=0x10, RAM[0x10]=0xDEADBEEF -> CE+RD with addr 0x10 at t+1; oDONE_F=1 and oRDATA=0xDEADBEEF at t+2.
REQ-036 Store then load: iREQ_S with addr 0x20, data 0x12345678 -> CE+WR at t+1, oDONE_S at t+2; then iREQ_I with addr 0x20 -> oDONE_I with oRDATA=0x12345678.
REQ-037 All three requests held high from reset -> grant order F, I, S, F, ...; oDONE pulses 3 cycles apart; never two oDONE in one cycle.
REQ-038 iREQ_I dropped during ACCESS -> oDONE_I still pulses in the next cycle; no second access issued for I.
REQ-039 iRST asserted during ACCESS of a store -> next cycle IDLE with all outputs 0 and no oDONE_S; RAM write of that ACCESS cycle is the only effect.
REQ-040 F and S requesting continuously with I idle -> strict F/S alternation; pointer skips I without a wasted cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Three-requester RAM arbiter: fetch (F), load (I) and store (S) share one
// single-port RAM. Requests are granted round-robin (F, I, S). Each grant
// takes three cycles: IDLE (grant), ACCESS (RAM strobe) and RESP (done pulse).
// Ports:
//   iCLK, iRST                   clock, synchronous active-high reset
//   iREQ_x / iADDR_x / iDATA_S   requester handshakes (x = F, I, S)
//   oDONE_x                      one-cycle completion pulse per requester
//   oRDATA                       read data, valid with oDONE_F / oDONE_I
//   oBUSY                        high while a transaction is in flight
//   oRAM_*                       RAM strobes, address and write data
//   iRAM_DATA_RD                 RAM read data, one cycle after CE+RD
module mem_arbiter #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iREQ_F,
   input  logic [ADDR_W-1:0] iADDR_F,
   input  logic              iREQ_I,
   input  logic [ADDR_W-1:0] iADDR_I,
   input  logic              iREQ_S,
   input  logic [ADDR_W-1:0] iADDR_S,
   input  logic [DATA_W-1:0] iDATA_S,
   output logic              oDONE_F,
   output logic              oDONE_I,
   output logic              oDONE_S,
   output logic [DATA_W-1:0] oRDATA,
   output logic              oBUSY,
   output logic              oRAM_CE,
   output logic              oRAM_RD,
   output logic              oRAM_WR,
   output logic [ADDR_W-1:0] oRAM_ADDR,
   output logic [DATA_W-1:0] oRAM_DATA_WR,
   input  logic [DATA_W-1:0] iRAM_DATA_RD
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [1:0] SEL_F = 2'd0;
   localparam logic [1:0] SEL_I = 2'd1;
   localparam logic [1:0] SEL_S = 2'd2;

   state_t            state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        sel_q;
   logic [1:0]        win;
   logic              found;
   logic              grant;
   logic [2:0]        req;
   logic [2:0]        cand;
   logic [1:0]        base;
   logic [ADDR_W-1:0] win_addr;
   logic              ce_d, rd_d, wr_d, busy_d;
   logic [2:0]        done_d;
   logic [DATA_W-1:0] rdata_q;

   assign req = {iREQ_S, iREQ_I, iREQ_F};

   // Round-robin search: first requester found starting at the pointer.
   always_comb begin
      found = 1'b0;
      win   = SEL_F;
      cand  = 3'd0;
      base  = (ptr_q == 2'd3) ? SEL_F : ptr_q;
      for (int k = 0; k < 3; k++) begin
         cand = 3'(base) + 3'(k);
         if (cand >= 3'd3) cand = cand - 3'd3;
         if (!found && req[cand[1:0]]) begin
            found = 1'b1;
            win   = cand[1:0];
         end
      end
   end

   always_comb begin
      case (win)
         SEL_F:   win_addr = iADDR_F;
         SEL_I:   win_addr = iADDR_I;
         default: win_addr = iADDR_S;
      endcase
   end

   // Next state plus next values of the registered outputs.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant   = 1'b0;
      ce_d    = 1'b0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      done_d  = 3'b000;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = ACCESS;
               grant   = 1'b1;
               ptr_d   = (win == SEL_S) ? SEL_F : win + 2'd1;
               ce_d    = 1'b1;
               rd_d    = (win != SEL_S);
               wr_d    = (win == SEL_S);
            end
         end
         ACCESS: begin
            state_d = RESP;
            done_d  = 3'b001 << sel_q;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q      <= IDLE;
         ptr_q        <= SEL_F;
         sel_q        <= SEL_F;
         oRAM_CE      <= 1'b0;
         oRAM_RD      <= 1'b0;
         oRAM_WR      <= 1'b0;
         oBUSY        <= 1'b0;
         oDONE_F      <= 1'b0;
         oDONE_I      <= 1'b0;
         oDONE_S      <= 1'b0;
         oRAM_ADDR    <= '0;
         oRAM_DATA_WR <= '0;
         rdata_q      <= '0;
      end else begin
         state_q                     <= state_d;
         ptr_q                       <= ptr_d;
         oRAM_CE                     <= ce_d;
         oRAM_RD                     <= rd_d;
         oRAM_WR                     <= wr_d;
         oBUSY                       <= busy_d;
         {oDONE_S, oDONE_I, oDONE_F} <= done_d;
         if (grant) begin
            sel_q     <= win;
            oRAM_ADDR <= win_addr;
            // Write data only moves for stores; reads leave the last value.
            if (win == SEL_S) oRAM_DATA_WR <= iDATA_S;
         end
         // Keep the read word so oRDATA holds it after RESP.
         if (state_q == RESP && sel_q != SEL_S) rdata_q <= iRAM_DATA_RD;
      end
   end

   // RAM data passes straight through in the read completion cycle.
   assign oRDATA = (oDONE_F || oDONE_I) ? iRAM_DATA_RD : rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, hand-written corner
// sequences and random traffic, all checked against a transaction model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_f = 1'b0, req_i = 1'b0, req_s = 1'b0;
   logic [7:0]  addr_f = '0, addr_i = '0, addr_s = '0;
   logic [31:0] data_s = '0;
   logic        done_f, done_i, done_s, busy, ram_ce, ram_rd, ram_wr;
   logic [31:0] rdata, ram_wd, ram_rdata;
   logic [7:0]  ram_addr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
      .iCLK(clk), .iRST(rst),
      .iREQ_F(req_f), .iADDR_F(addr_f),
      .iREQ_I(req_i), .iADDR_I(addr_i),
      .iREQ_S(req_s), .iADDR_S(addr_s), .iDATA_S(data_s),
      .oDONE_F(done_f), .oDONE_I(done_i), .oDONE_S(done_s),
      .oRDATA(rdata), .oBUSY(busy),
      .oRAM_CE(ram_ce), .oRAM_RD(ram_rd), .oRAM_WR(ram_wr),
      .oRAM_ADDR(ram_addr), .oRAM_DATA_WR(ram_wd),
      .iRAM_DATA_RD(ram_rdata)
   );

   // Synchronous RAM attached to the arbiter.
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (ram_ce) begin
         if (ram_wr) mem[ram_addr] <= ram_wd;
         if (ram_rd) ram_rdata <= mem[ram_addr];
      end
   end

   // Observed outputs: {done S,I,F, busy, ce, rd, wr, addr, wdata, rdata}.
   logic [78:0] obs;
   assign obs = {done_s, done_i, done_f, busy, ram_ce, ram_rd, ram_wr,
                 ram_addr, ram_wd, rdata};

   // Transaction-level model: phase counts cycles since the grant (0 = idle).
   logic [31:0] ref_mem [256];
   int          m_phase = 0, m_ptr = 0, m_win = 0;
   logic [7:0]  m_addr = '0;
   logic [31:0] m_wd = '0, m_hold = '0;
   logic [78:0] exp_obs;

   function automatic bit req_bit(input int idx);
      case (idx)
         0:       return req_f;
         1:       return req_i;
         default: return req_s;
      endcase
   endfunction

   task automatic model_step();
      bit got;
      int w;
      got = 1'b0;
      w   = 0;
      if (m_phase == 1 && m_win == 2) ref_mem[m_addr] = m_wd;
      if (rst) begin
         m_phase = 0; m_ptr = 0; m_addr = '0; m_wd = '0; m_hold = '0;
      end else if (m_phase == 0) begin
         for (int k = 0; k < 3; k++)
            if (!got && req_bit((m_ptr + k) % 3)) begin
               got = 1'b1;
               w   = (m_ptr + k) % 3;
            end
         if (got) begin
            m_win   = w;
            m_ptr   = (w + 1) % 3;
            m_phase = 1;
            m_addr  = (w == 0) ? addr_f : (w == 1) ? addr_i : addr_s;
            if (w == 2) m_wd = data_s;
         end
      end else begin
         m_phase = (m_phase + 1) % 3;
      end
      if (m_phase == 2 && m_win != 2) m_hold = ref_mem[m_addr];
      exp_obs = {(m_phase == 2) ? 3'(1 << m_win) : 3'b000,
                 m_phase != 0, m_phase == 1,
                 m_phase == 1 && m_win != 2, m_phase == 1 && m_win == 2,
                 m_addr, m_wd, m_hold};
   endtask

   task automatic check(input string name, input logic [127:0] got,
                        input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One clock: advance the model, let the edge pass, compare after it.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("model", 128'(obs), 128'(exp_obs));
   endtask

   typedef struct {
      logic        rst;
      logic [2:0]  req;     // {S, I, F}
      logic [7:0]  addr;    // applied to all three requesters
      logic [31:0] wdata;
      logic [2:0]  done;    // {S, I, F}
      logic        busy, ce, rd, wr;
      logic [7:0]  raddr;
      logic [31:0] rdata;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic [2:0] q,
                               input logic [7:0] a, input logic [31:0] d,
                               input logic [2:0] dn, input logic b, input logic c,
                               input logic rr, input logic ww,
                               input logic [7:0] ra, input logic [31:0] rd);
      vec_t v;
      v.rst = r; v.req = q; v.addr = a; v.wdata = d;
      v.done = dn; v.busy = b; v.ce = c; v.rd = rr; v.wr = ww;
      v.raddr = ra; v.rdata = rd;
      return v;
   endfunction

   vec_t        tbl [22];
   int          done_tick [$];
   int          done_id [$];
   logic [7:0]  ids;
   logic        seen;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'hA500_0000 + 32'(i);
         ref_mem[i] = 32'hA500_0000 + 32'(i);
      end
      mem[8'h10]     = 32'hDEAD_BEEF;
      ref_mem[8'h10] = 32'hDEAD_BEEF;

      // Single fetch, store then load, then all three requesters held.
      tbl[0]  = mk(1, 3'b000, 8'h00, 32'h0,         3'b000, 0, 0, 0, 0, 8'h00, 32'h0);
      tbl[1]  = mk(0, 3'b001, 8'h10, 32'h0,         3'b000, 1, 1, 1, 0, 8'h10, 32'h0);
      tbl[2]  = mk(0, 3'b001, 8'h10, 32'h0,         3'b001, 1, 0, 0, 0, 8'h10, 32'hDEAD_BEEF);
      tbl[3]  = mk(0, 3'b000, 8'h10, 32'h0,         3'b000, 0, 0, 0, 0, 8'h10, 32'hDEAD_BEEF);
      tbl[4]  = mk(0, 3'b100, 8'h20, 32'h1234_5678, 3'b000, 1, 1, 0, 1, 8'h20, 32'hDEAD_BEEF);
      tbl[5]  = mk(0, 3'b100, 8'h20, 32'h1234_5678, 3'b100, 1, 0, 0, 0, 8'h20, 32'hDEAD_BEEF);
      tbl[6]  = mk(0, 3'b010, 8'h20, 32'h0,         3'b000, 0, 0, 0, 0, 8'h20, 32'hDEAD_BEEF);
      tbl[7]  = mk(0, 3'b010, 8'h20, 32'h0,         3'b000, 1, 1, 1, 0, 8'h20, 32'hDEAD_BEEF);
      tbl[8]  = mk(0, 3'b010, 8'h20, 32'h0,         3'b010, 1, 0, 0, 0, 8'h20, 32'h1234_5678);
      tbl[9]  = mk(0, 3'b000, 8'h20, 32'h0,         3'b000, 0, 0, 0, 0, 8'h20, 32'h1234_5678);
      tbl[10] = mk(1, 3'b111, 8'h30, 32'hCAFE_F00D, 3'b000, 0, 0, 0, 0, 8'h00, 32'h0);
      tbl[11] = mk(0, 3'b111, 8'h30, 32'hCAFE_F00D, 3'b000, 1, 1, 1, 0, 8'h30, 32'h0);
      tbl[12] = mk(0, 3'b111, 8'h30, 32'hCAFE_F00D, 3'b001, 1, 0, 0, 0, 8'h30, 32'hA500_0030);
      tbl[13] = mk(0, 3'b111, 8'h30, 32'hCAFE_F00D, 3'b000, 0, 0, 0, 0, 8'h30, 32'hA500_0030);
      tbl[14] = mk(0, 3'b111, 8'h30, 32'hCAFE_F00D, 3'b000, 1, 1, 1, 0, 8'h30, 32'hA500_0030);
      tbl[15] = mk(0, 3'b111, 8'h30, 32'hCAFE_F00D, 3'b010, 1, 0, 0, 0, 8'h30, 32'hA500_0030);
      tbl[16] = mk(0, 3'b111, 8'h30, 32'hCAFE_F00D, 3'b000, 0, 0, 0, 0, 8'h30, 32'hA500_0030);
      tbl[17] = mk(0, 3'b111, 8'h30, 32'hCAFE_F00D, 3'b000, 1, 1, 0, 1, 8'h30, 32'hA500_0030);
      tbl[18] = mk(0, 3'b111, 8'h30, 32'hCAFE_F00D, 3'b100, 1, 0, 0, 0, 8'h30, 32'hA500_0030);
      tbl[19] = mk(0, 3'b111, 8'h30, 32'hCAFE_F00D, 3'b000, 0, 0, 0, 0, 8'h30, 32'hA500_0030);
      tbl[20] = mk(0, 3'b111, 8'h30, 32'hCAFE_F00D, 3'b000, 1, 1, 1, 0, 8'h30, 32'hA500_0030);
      tbl[21] = mk(0, 3'b111, 8'h30, 32'hCAFE_F00D, 3'b001, 1, 0, 0, 0, 8'h30, 32'hCAFE_F00D);

      for (int i = 0; i < 22; i++) begin
         rst = tbl[i].rst;
         {req_s, req_i, req_f} = tbl[i].req;
         addr_f = tbl[i].addr; addr_i = tbl[i].addr; addr_s = tbl[i].addr;
         data_s = tbl[i].wdata;
         tick();
         check($sformatf("table_row%0d", i), 128'({obs[78:64], obs[31:0]}),
               128'({tbl[i].done, tbl[i].busy, tbl[i].ce, tbl[i].rd, tbl[i].wr,
                     tbl[i].raddr, tbl[i].rdata}));
      end

      // Load request dropped during ACCESS still completes, once.
      {req_s, req_i, req_f} = 3'b000;
      tick();
      req_i = 1'b1; addr_i = 8'h05;
      tick();
      check("i_access", 128'({ram_ce, ram_rd, ram_addr}), 128'({2'b11, 8'h05}));
      req_i = 1'b0;
      tick();
      check("i_done_after_drop", 128'({done_s, done_i, done_f}), 128'(3'b010));
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         seen |= ram_ce | done_i;
      end
      check("i_no_reaccess", 128'(seen), 128'(1'b0));

      // Reset during a store ACCESS: no done, but the RAM write lands.
      req_s = 1'b1; addr_s = 8'h06; data_s = 32'h1111_2222;
      tick();
      check("s_access", 128'({ram_ce, ram_wr}), 128'(2'b11));
      rst = 1'b1;
      tick();
      check("rst_mid_access", 128'(obs), 128'(79'd0));
      rst = 1'b0; req_s = 1'b0;
      tick();
      check("no_done_after_rst", 128'({done_s, busy}), 128'(2'b00));
      req_i = 1'b1; addr_i = 8'h06;
      tick();
      req_i = 1'b0;
      tick();
      check("write_landed", 128'({done_i, rdata}), 128'({1'b1, 32'h1111_2222}));
      tick();

      // F and S held with I idle: strict alternation, every third cycle.
      req_f = 1'b1; req_s = 1'b1; addr_f = 8'h01; addr_s = 8'h02;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (done_f) begin done_tick.push_back(t); done_id.push_back(0); end
         if (done_i) begin done_tick.push_back(t); done_id.push_back(1); end
         if (done_s) begin done_tick.push_back(t); done_id.push_back(2); end
      end
      check("fs_done_count", 128'(done_id.size()), 128'(4));
      ids = '0;
      for (int k = 0; k < done_id.size() && k < 4; k++)
         ids = {ids[5:0], 2'(done_id[k])};
      check("fs_alternation", 128'(ids), 128'(8'b10_00_10_00));
      check("fs_spacing", 128'(done_tick.size() == 4 ? {8'(done_tick[0]), 8'(done_tick[1]),
                                                         8'(done_tick[2]), 8'(done_tick[3])} : 32'h0),
            128'({8'd2, 8'd5, 8'd8, 8'd11}));
      {req_s, req_i, req_f} = 3'b000;
      tick(); tick(); tick();

      // Random traffic with occasional reset, small address range for reuse.
      for (int c = 0; c < 3000; c++) begin
         rst    = ($urandom_range(0, 59) == 0);
         req_f  = ($urandom_range(0, 2) != 0);
         req_i  = ($urandom_range(0, 2) == 0);
         req_s  = ($urandom_range(0, 1) == 0);
         addr_f = 8'($urandom_range(0, 7));
         addr_i = 8'($urandom_range(0, 7));
         addr_s = 8'($urandom_range(0, 7));
         data_s = $urandom;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
